// File: rtl/mux_scan_reg.sv
// Registered NCH-channel, WIDTH-bit multiplexer with valid/ready output and a round-robin scan mode.
// Optional MUX_PARITY_EN adds out_par, the XOR of the captured word.
module mux_scan_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int SELW  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   in_bus,
  input  logic [SELW-1:0]        sel,
  input  logic                   mode,
  input  logic                   load,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_sel,
  output logic                   out_err,
`ifdef MUX_PARITY_EN
  output logic                   out_par,
`endif
  output logic                   busy
);

  localparam logic [SELW:0]   NCH_EXT = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST    = SELW'(NCH - 1);

  logic [SELW-1:0]  ptr;
  logic             mode_q;
  logic             free;
  logic             capture;
  logic             scan_entry;
  logic [SELW-1:0]  ptr_use;
  logic [SELW-1:0]  ptr_next;
  logic [SELW-1:0]  idx;
  logic             idx_err;
  logic [WIDTH-1:0] word;

  assign free       = !out_valid || out_ready;
  assign capture    = load && free;
  // The pointer restarts at channel 0 on the very cycle scan mode is entered.
  assign scan_entry = mode && !mode_q;
  assign ptr_use    = scan_entry ? '0 : ptr;
  assign ptr_next   = (ptr_use == LAST) ? '0 : ptr_use + 1'b1;
  assign idx        = mode ? ptr_use : sel;
  assign idx_err    = {1'b0, idx} >= NCH_EXT;
  assign busy       = out_valid && !out_ready;

  // Out-of-range indices match no channel, so word stays zero for them.
  always_comb begin
    word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) word = in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      ptr       <= '0;
      mode_q    <= 1'b0;
`ifdef MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      mode_q <= mode;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_sel   <= idx;
        out_err   <= idx_err;
`ifdef MUX_PARITY_EN
        out_par   <= ^word;
`endif
        if (mode) ptr <= ptr_next;
      end else begin
        if (scan_entry) ptr <= '0;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Self-checking bench for mux_scan_reg: directed scenarios plus a randomized run against a queue-free reference model.
// Build with +define+MUX_PARITY_EN to also cover out_par.
module tb_mux_scan_reg;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N*W-1:0] in_bus;
  logic [2:0] sel;
  logic mode, load, out_ready;
  logic out_valid, out_err, busy;
  logic [W-1:0] out_data;
  logic [2:0] out_sel;
`ifdef MUX_PARITY_EN
  logic out_par;
  logic par6;
`endif

  logic [6*W-1:0] in_bus6;
  logic [2:0] sel6;
  logic load6;
  logic v6, e6, busy6;
  logic [W-1:0] d6;
  logic [2:0] s6;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit       m_valid;
  bit [31:0] m_data;
  int       m_sel;
  bit       m_err;
  int       m_ptr;
  bit       m_mode_q;

  always #5 clk = ~clk;

  mux_scan_reg #(.WIDTH(W), .NCH(N), .SELW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .mode(mode),
    .load(load), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .busy(busy));

  mux_scan_reg #(.WIDTH(W), .NCH(6), .SELW(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus6), .sel(sel6), .mode(1'b0),
    .load(load6), .out_ready(1'b1), .out_valid(v6),
    .out_data(d6), .out_sel(s6), .out_err(e6),
`ifdef MUX_PARITY_EN
    .out_par(par6),
`endif
    .busy(busy6));

  function automatic logic [31:0] chan(input int k);
    return in_bus[k*W +: W];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_err = 0; m_ptr = 0; m_mode_q = 0;
  endtask

  // Reference: one transfer slot, pointer counts modulo N and restarts on scan entry.
  task automatic model_step();
    bit cap;
    int idx;
    cap = load && (!m_valid || out_ready);
    if (mode && !m_mode_q) m_ptr = 0;
    idx = mode ? m_ptr : int'(sel);
    if (cap) begin
      m_valid = 1;
      m_sel   = idx;
      m_err   = (idx >= N);
      m_data  = (idx < N) ? chan(idx) : 32'h0;
      if (mode) m_ptr = (m_ptr + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    m_mode_q = mode;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_channels();
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = 32'hA000_0000 + k;
    for (int k = 0; k < 6; k++) in_bus6[k*W +: W] = 32'hB000_0000 + k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 0; mode = 0; sel = 0; out_ready = 1; load6 = 0; sel6 = 0;
    set_channels();
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: got v=%b d=%h s=%0d e=%b expected all zero", out_valid, out_data, out_sel, out_err);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    // load a word and stall it, then reset mid-transfer without a clock edge
    sel = 3'd2; load = 1; out_ready = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA000_0002) begin
      failures++;
      $display("FAIL reset_pre_load: got v=%b d=%h expected v=1 d=a0000002", out_valid, out_data);
    end
    load = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("FAIL reset_async_data: got %h expected 0", out_data); end
    checks++;
    if (out_sel !== 3'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_sel_err: got s=%0d e=%b expected 0 0", out_sel, out_err);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1;
  endtask

  task automatic test_direct();
    set_channels();
    mode = 0; sel = 3'd5; load = 1; out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA000_0005 || out_sel !== 3'd5 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL direct_sel5: got v=%b d=%h s=%0d e=%b expected 1 a0000005 5 0", out_valid, out_data, out_sel, out_err);
    end
    load = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hA000_0005) begin
      failures++;
      $display("FAIL drain: got v=%b d=%h expected v=0 d=a0000005", out_valid, out_data);
    end
  endtask

  task automatic test_out_of_range();
    sel6 = 3'd7; load6 = 1;
    tick();
    checks++;
    if (v6 !== 1'b1 || d6 !== 32'h0 || s6 !== 3'd7 || e6 !== 1'b1) begin
      failures++;
      $display("FAIL oor_sel7: got v=%b d=%h s=%0d e=%b expected 1 0 7 1", v6, d6, s6, e6);
    end
    sel6 = 3'd5;
    tick();
    checks++;
    if (v6 !== 1'b1 || d6 !== 32'hB000_0005 || s6 !== 3'd5 || e6 !== 1'b0) begin
      failures++;
      $display("FAIL oor_last_valid: got v=%b d=%h s=%0d e=%b expected 1 b0000005 5 0", v6, d6, s6, e6);
    end
    load6 = 0;
    tick();
  endtask

  task automatic test_scan_wrap();
    set_channels();
    mode = 0; load = 0; out_ready = 1;
    tick();
    mode = 1; load = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'(i % N) || out_data !== 32'hA000_0000 + (i % N) || out_err !== 1'b0) begin
        failures++;
        $display("FAIL scan_wrap[%0d]: got s=%0d d=%h v=%b e=%b expected s=%0d", i, out_sel, out_data, out_valid, out_err, i % N);
      end
    end
    load = 0; mode = 0;
    tick();
  endtask

  task automatic test_backpressure();
    set_channels();
    mode = 0; load = 0; out_ready = 1;
    tick();
    mode = 1; load = 1;
    tick();
    checks++;
    if (out_sel !== 3'd0 || out_data !== 32'hA000_0000) begin
      failures++;
      $display("FAIL bp_first: got s=%0d d=%h expected 0 a0000000", out_sel, out_data);
    end
    out_ready = 0;
    in_bus[0 +: W] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 32'hA000_0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h busy=%b expected 1 0 a0000000 1", i, out_valid, out_sel, out_data, busy);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_release: got %b expected 0", busy); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'd1 || out_data !== 32'hA000_0001) begin
      failures++;
      $display("FAIL bp_resume: got v=%b s=%0d d=%h expected 1 1 a0000001", out_valid, out_sel, out_data);
    end
    load = 0; mode = 0;
    tick();
  endtask

  task automatic test_parity();
`ifdef MUX_PARITY_EN
    set_channels();
    in_bus[3*W +: W] = 32'h0000_0007;
    in_bus[2*W +: W] = 32'h0000_0003;
    mode = 0; out_ready = 1; load = 1; sel = 3'd3;
    tick();
    checks++;
    if (out_par !== 1'b1) begin failures++; $display("FAIL parity_7: got %b expected 1", out_par); end
    sel = 3'd2;
    tick();
    checks++;
    if (out_par !== 1'b0) begin failures++; $display("FAIL parity_3: got %b expected 0", out_par); end
    sel6 = 3'd6; load6 = 1;
    load = 0;
    tick();
    checks++;
    if (par6 !== 1'b0) begin failures++; $display("FAIL parity_oor: got %b expected 0", par6); end
    load6 = 0;
    tick();
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) in_bus[k*W +: W] = $urandom;
      sel = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 2) mode = ~mode;
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== 3'(m_sel) || out_err !== m_err ||
          busy !== (m_valid && !out_ready)) begin
        failures++;
        $display("FAIL random[%0d]: got v=%b d=%h s=%0d e=%b busy=%b expected v=%b d=%h s=%0d e=%b busy=%b",
                 c, out_valid, out_data, out_sel, out_err, busy,
                 m_valid, m_data, m_sel, m_err, m_valid && !out_ready);
      end
`ifdef MUX_PARITY_EN
      checks++;
      if (out_par !== ^m_data) begin
        failures++;
        $display("FAIL random_par[%0d]: got %b expected %b", c, out_par, ^m_data);
      end
`endif
    end
    load = 0; mode = 0; out_ready = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_scan_wrap();
    test_backpressure();
    test_parity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1);
  end

endmodule
